// File: rtl/instqueue.sv
// Circular instruction buffer between fetch and decode: absorbs fetch bursts,
// presents the head one instruction per cycle, and handles JAL / ROB flushes.
module instqueue #(
   parameter int DEPTH_LOG = 4,
   parameter int IDW       = 32,
   parameter int AW        = 32
) (
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic           rdy_in,
   input  logic           if_instqueue_en_in,
   input  logic [IDW-1:0] if_instqueue_inst_in,
   input  logic [AW-1:0]  if_instqueue_pc_in,
   output logic           instqueue_if_full_out,
   output logic           instqueue_decoder_en_out,
   output logic [IDW-1:0] instqueue_decoder_inst_out,
   output logic [AW-1:0]  instqueue_decoder_pc_out,
   input  logic           decoder_instqueue_rst_in,
   input  logic           dispatcher_instqueue_stall_in,
   input  logic           rob_instqueue_rst_in
);

   localparam int                 DEPTH       = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] CNT_DEPTH   = (DEPTH_LOG+1)'(DEPTH);
   localparam logic [DEPTH_LOG:0] CNT_THRESH  = (DEPTH_LOG+1)'(DEPTH - 1);
   localparam logic [DEPTH_LOG:0] CNT_ONE     = (DEPTH_LOG+1)'(1);

   logic [DEPTH_LOG-1:0] r_head;
   logic [DEPTH_LOG-1:0] r_tail;
   logic [DEPTH_LOG:0]   r_count;
   logic                 r_full;

   logic [IDW-1:0]       r_inst_mem [DEPTH];
   logic [AW-1:0]        r_pc_mem   [DEPTH];

   logic                 w_nonempty;
   logic                 w_pop;
   logic                 w_push;
   logic [DEPTH_LOG-1:0] w_head_next;
   logic [DEPTH_LOG-1:0] w_tail_next;
   logic [DEPTH_LOG:0]   w_count_next;
   logic                 w_full_next;

   assign w_nonempty = (r_count != '0);

   assign w_pop  = rdy_in && !rst_in && !rob_instqueue_rst_in && w_nonempty
                   && !dispatcher_instqueue_stall_in;

   assign w_push = rdy_in && !rst_in && !rob_instqueue_rst_in && !decoder_instqueue_rst_in
                   && if_instqueue_en_in && (r_count != CNT_DEPTH);

   always_comb begin
      w_head_next  = r_head;
      w_tail_next  = r_tail;
      w_count_next = r_count;
      w_full_next  = r_full;
      if (!rdy_in) begin
         w_head_next = r_head;
      end else if (rob_instqueue_rst_in) begin
         w_head_next  = '0;
         w_tail_next  = '0;
         w_count_next = '0;
         w_full_next  = 1'b0;
      end else if (decoder_instqueue_rst_in) begin
         w_full_next = 1'b0;
         if (w_pop || !w_nonempty) begin
            w_head_next  = '0;
            w_tail_next  = '0;
            w_count_next = '0;
         end else begin
            // Stalled JAL stays at head so the redirect can fire again on its pop.
            w_tail_next  = r_head + 1'b1;
            w_count_next = CNT_ONE;
         end
      end else begin
         w_head_next  = r_head + DEPTH_LOG'(w_pop);
         w_tail_next  = r_tail + DEPTH_LOG'(w_push);
         w_count_next = r_count + (DEPTH_LOG+1)'(w_push) - (DEPTH_LOG+1)'(w_pop);
         w_full_next  = (w_count_next >= CNT_THRESH);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         r_head  <= w_head_next;
         r_tail  <= w_tail_next;
         r_count <= w_count_next;
         r_full  <= w_full_next;
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_inst_mem[r_tail] <= if_instqueue_inst_in;
         r_pc_mem[r_tail]   <= if_instqueue_pc_in;
      end
   end

   assign instqueue_if_full_out      = r_full;
   assign instqueue_decoder_en_out   = w_pop;
   assign instqueue_decoder_inst_out = (!rst_in && w_nonempty) ? r_inst_mem[r_head] : '0;
   assign instqueue_decoder_pc_out   = (!rst_in && w_nonempty) ? r_pc_mem[r_head]   : '0;

endmodule

// File: tb/tb_instqueue.sv
// Bench for instqueue: a directed vector table, hand-written flush/wrap sequences
// and random traffic, all compared against a queue-based reference model.
module tb_instqueue;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, if_en, stall_in, dec_rst, rob_rst;
   logic [31:0] if_inst, if_pc;
   logic        full_out, dec_en;
   logic [31:0] dec_inst, dec_pc;

   always #5 clk_in = ~clk_in;

   instqueue #(.DEPTH_LOG(4), .IDW(32), .AW(32)) dut (
      .clk_in                        (clk_in),
      .rst_in                        (rst_in),
      .rdy_in                        (rdy_in),
      .if_instqueue_en_in            (if_en),
      .if_instqueue_inst_in          (if_inst),
      .if_instqueue_pc_in            (if_pc),
      .instqueue_if_full_out         (full_out),
      .instqueue_decoder_en_out      (dec_en),
      .instqueue_decoder_inst_out    (dec_inst),
      .instqueue_decoder_pc_out      (dec_pc),
      .decoder_instqueue_rst_in      (dec_rst),
      .dispatcher_instqueue_stall_in (stall_in),
      .rob_instqueue_rst_in          (rob_rst)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   typedef struct {
      bit          rst;
      bit          en;
      logic [31:0] inst;
      logic [31:0] pc;
      bit          stall;
      bit          exp_en;
      logic [31:0] exp_inst;
      logic [31:0] exp_pc;
      bit          exp_full;
   } vec_t;

   entry_t      model_q[$];
   bit          model_full = 1'b0;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic        obs_en, obs_full;
   logic [31:0] obs_inst, obs_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // One clock of stimulus: drive, check against the model, then advance the model.
   task automatic step(input bit a_rst, input bit a_rdy, input bit a_en,
                       input logic [31:0] a_inst, input logic [31:0] a_pc,
                       input bit a_stall, input bit a_dec, input bit a_rob);
      bit          pop;
      bit          e_en;
      logic [31:0] e_inst, e_pc;
      entry_t      h;
      rst_in = a_rst; rdy_in = a_rdy; if_en = a_en; if_inst = a_inst; if_pc = a_pc;
      stall_in = a_stall; dec_rst = a_dec; rob_rst = a_rob;
      pop    = a_rdy && !a_rst && !a_rob && (model_q.size() != 0) && !a_stall;
      e_en   = pop;
      e_inst = (!a_rst && model_q.size() != 0) ? model_q[0].inst : 32'h0;
      e_pc   = (!a_rst && model_q.size() != 0) ? model_q[0].pc   : 32'h0;
      @(negedge clk_in);
      obs_en = dec_en; obs_inst = dec_inst; obs_pc = dec_pc; obs_full = full_out;
      chk("en_out",   32'(obs_en),   32'(e_en));
      chk("inst_out", obs_inst,      e_inst);
      chk("pc_out",   obs_pc,        e_pc);
      chk("full_out", 32'(obs_full), 32'(model_full));
      $display("cyc=%0d rst=%b rdy=%b push=%b stall=%b dec=%b rob=%b | en=%b inst=%h pc=%h full=%b qlen=%0d",
               cyc, a_rst, a_rdy, a_en, a_stall, a_dec, a_rob, obs_en, obs_inst, obs_pc, obs_full,
               model_q.size());
      @(posedge clk_in);
      if (a_rst) begin
         model_q.delete();
         model_full = 1'b0;
      end else if (!a_rdy) begin
         model_full = model_full;
      end else if (a_rob) begin
         model_q.delete();
         model_full = 1'b0;
      end else if (a_dec) begin
         if (!pop && model_q.size() != 0) begin
            h = model_q[0];
            model_q.delete();
            model_q.push_back(h);
         end else begin
            model_q.delete();
         end
         model_full = 1'b0;
      end else begin
         if (a_en) begin
            total++;
            if (model_q.size() == 16) begin
               bad++;
               $display("FAIL protocol_overflow cyc=%0d actual=push_at_16 required=no_push", cyc);
            end
         end
         if (a_en && model_q.size() != 16) begin
            if (pop) void'(model_q.pop_front());
            h.inst = a_inst;
            h.pc   = a_pc;
            model_q.push_back(h);
         end else if (pop) begin
            void'(model_q.pop_front());
         end
         model_full = (model_q.size() >= 15);
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input bit a_stall);
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, a_stall, 1'b0, 1'b0);
   endtask

   task automatic push(input logic [31:0] a_inst, input logic [31:0] a_pc, input bit a_stall);
      step(1'b0, 1'b1, 1'b1, a_inst, a_pc, a_stall, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   vec_t tbl[6];

   initial begin
      tbl[0] = '{rst:1, en:0, inst:32'h0,        pc:32'h0, stall:0, exp_en:0, exp_inst:32'h0,        exp_pc:32'h0, exp_full:0};
      tbl[1] = '{rst:0, en:1, inst:32'h00000013, pc:32'h0, stall:0, exp_en:0, exp_inst:32'h0,        exp_pc:32'h0, exp_full:0};
      tbl[2] = '{rst:0, en:1, inst:32'h00100093, pc:32'h4, stall:0, exp_en:1, exp_inst:32'h00000013, exp_pc:32'h0, exp_full:0};
      tbl[3] = '{rst:0, en:1, inst:32'h00200113, pc:32'h8, stall:0, exp_en:1, exp_inst:32'h00100093, exp_pc:32'h4, exp_full:0};
      tbl[4] = '{rst:0, en:0, inst:32'h0,        pc:32'h0, stall:0, exp_en:1, exp_inst:32'h00200113, exp_pc:32'h8, exp_full:0};
      tbl[5] = '{rst:0, en:0, inst:32'h0,        pc:32'h0, stall:0, exp_en:0, exp_inst:32'h0,        exp_pc:32'h0, exp_full:0};

      for (int i = 0; i < 6; i++) begin
         step(tbl[i].rst, 1'b1, tbl[i].en, tbl[i].inst, tbl[i].pc, tbl[i].stall, 1'b0, 1'b0);
         chk("tbl_en",   32'(obs_en),   32'(tbl[i].exp_en));
         chk("tbl_inst", obs_inst,      tbl[i].exp_inst);
         chk("tbl_pc",   obs_pc,        tbl[i].exp_pc);
         chk("tbl_full", 32'(obs_full), 32'(tbl[i].exp_full));
      end

      // Fill to 16 under stall, then drain in order across the wrap.
      do_reset();
      for (int i = 0; i < 16; i++) push($urandom, 32'h1000 + 32'(i * 4), 1'b1);
      idle(1'b1);
      chk("full_at_16", 32'(obs_full), 32'd1);
      for (int i = 0; i < 17; i++) idle(1'b0);
      chk("empty_after_drain", 32'(obs_en), 32'd0);

      // Simultaneous push/pop at 15 entries, tail crossing index 15 -> 0.
      do_reset();
      for (int i = 0; i < 15; i++) push($urandom, 32'h2000 + 32'(i * 4), 1'b1);
      for (int i = 0; i < 6; i++) push($urandom, 32'h3000 + 32'(i * 4), 1'b0);
      for (int i = 0; i < 16; i++) idle(1'b0);

      // JAL redirect with pop and concurrent fetch.
      do_reset();
      push(32'h0000006f, 32'h100, 1'b1);
      for (int i = 0; i < 4; i++) push($urandom, 32'h104 + 32'(i * 4), 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'hdeadbeef, 32'h500, 1'b0, 1'b1, 1'b0);
      chk("jal_popped_pc", obs_pc, 32'h100);
      idle(1'b0);
      chk("after_jal_en", 32'(obs_en), 32'd0);

      // JAL redirect while stalled keeps the JAL at head.
      do_reset();
      push(32'h0000006f, 32'h100, 1'b1);
      for (int i = 0; i < 4; i++) push($urandom, 32'h104 + 32'(i * 4), 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'hdeadbeef, 32'h500, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("jal_kept_en", 32'(obs_en), 32'd1);
      chk("jal_kept_pc", obs_pc, 32'h100);
      idle(1'b0);

      // ROB flush beats everything; rdy low freezes state.
      do_reset();
      for (int i = 0; i < 8; i++) push($urandom, 32'h4000 + 32'(i * 4), 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h1234, 32'h600, 1'b0, 1'b1, 1'b1);
      chk("rob_flush_en", 32'(obs_en), 32'd0);
      idle(1'b0);
      for (int i = 0; i < 5; i++) push($urandom, 32'h5000 + 32'(i * 4), 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, $urandom, 32'h700, 1'b0, 1'(i == 1), 1'(i == 2));
         chk("frozen_en", 32'(obs_en), 32'd0);
      end
      for (int i = 0; i < 6; i++) idle(1'b0);

      // Random traffic; fetch honours full_out.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit r_rst, r_rdy, r_en, r_stall, r_dec, r_rob;
         r_rst   = ($urandom_range(199) == 0);
         r_rdy   = ($urandom_range(9) != 0);
         r_en    = !model_full && ($urandom_range(9) < 7);
         r_stall = ($urandom_range(9) < 3);
         r_dec   = ($urandom_range(24) == 0);
         r_rob   = ($urandom_range(39) == 0);
         step(r_rst, r_rdy, r_en, $urandom, {$urandom} & 32'hffff_fffc, r_stall, r_dec, r_rob);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
